// File: rtl/chan_readout_sched.sv
// Event readout sequencer: walks enabled channels after an EOS edge and streams header/data/trailer words.
// Optional macro CHAN_ID_EN places the channel id in the low nibble of each data word.
module chan_readout_sched #(
    parameter int CHAN      = 8,
    parameter int ADC_WIDTH = 12,
    parameter int WIDTH     = 16,
    parameter int NS_BITS   = 12
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EOS,
    input  logic [CHAN-1:0]           CHAN_MASK,
    input  logic [NS_BITS-1:0]        SAMPLE_NUM,
    input  logic [ADC_WIDTH*CHAN-1:0] CH_DATA,
    output logic [CHAN-1:0]           RD_REQUEST,
    output logic [WIDTH-1:0]          DOUT,
    output logic                      DOUT_VALID,
    input  logic                      DOUT_READY,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      OVERRUN
);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_HEADER, S_DATA, S_SETTLE, S_NEXT, S_TRAILER, S_FIN
    } state_t;

    localparam logic [NS_BITS-1:0] SC_ONE = 1;

    state_t               r_state, w_state_n;
    logic                 r_eos_q;
    logic                 r_ovr;
    logic                 r_vld, w_vld_n;
    logic [WIDTH-1:0]     r_dout, w_dout_n;
    logic [CHAN-1:0]      r_mask_l, w_mask_n;
    logic [NS_BITS-1:0]   r_ns_l, w_ns_n;
    logic [3:0]           r_ch, w_ch_n;
    logic [NS_BITS-1:0]   r_sc, w_sc_n;
    logic [7:0]           r_cnt, w_cnt_n;

    logic                 w_eos_edge;
    logic                 w_xfer;
    logic [NS_BITS-1:0]   w_sc_inc;
    logic [CHAN-1:0]      w_ch_onehot;
    logic [CHAN-1:0]      w_mask_rem;
    logic [ADC_WIDTH-1:0] w_sel;
    logic [WIDTH-1:0]     w_data_word;

    function automatic logic [3:0] f_lowest(input logic [CHAN-1:0] m);
        f_lowest = '0;
        for (int i = CHAN - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = 4'(i);
        end
    endfunction

    function automatic logic [WIDTH-1:0] f_header(input logic [3:0] ch);
        f_header = {4'hA, ch, 8'h00};
    endfunction

    function automatic logic [WIDTH-1:0] f_trailer(input logic [7:0] cnt);
        f_trailer = {4'hE, 4'h0, cnt};
    endfunction

    assign w_eos_edge = EOS & ~r_eos_q;
    assign w_xfer     = r_vld & DOUT_READY;
    assign w_sc_inc   = r_sc + SC_ONE;
    assign w_mask_rem = r_mask_l & ~w_ch_onehot;

    always_comb begin
        w_ch_onehot = '0;
        w_sel       = '0;
        for (int i = 0; i < CHAN; i++) begin
            if (int'(r_ch) == i) begin
                w_ch_onehot[i] = 1'b1;
                w_sel          = CH_DATA[i*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end

`ifdef CHAN_ID_EN
    assign w_data_word = {w_sel, r_ch};
`else
    assign w_data_word = {w_sel, 4'h0};
`endif

    // Next-state / next-register logic; DOUT is loaded on entry to each
    // valid-holding state so it cannot change until the transfer.
    always_comb begin
        w_state_n  = r_state;
        w_dout_n   = r_dout;
        w_vld_n    = r_vld;
        w_mask_n   = r_mask_l;
        w_ns_n     = r_ns_l;
        w_ch_n     = r_ch;
        w_sc_n     = r_sc;
        w_cnt_n    = r_cnt;
        RD_REQUEST = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_eos_edge) begin
                    w_mask_n  = CHAN_MASK;
                    w_ns_n    = SAMPLE_NUM;
                    w_cnt_n   = '0;
                    w_state_n = S_LATCH;
                end
            end
            S_LATCH: begin
                w_vld_n = 1'b1;
                if (r_mask_l == '0 || r_ns_l == '0) begin
                    w_dout_n  = f_trailer(r_cnt);
                    w_state_n = S_TRAILER;
                end else begin
                    w_ch_n    = f_lowest(r_mask_l);
                    w_dout_n  = f_header(f_lowest(r_mask_l));
                    w_state_n = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_xfer) begin
                    w_sc_n    = '0;
                    w_cnt_n   = r_cnt + 8'd1;
                    w_dout_n  = w_data_word;
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    RD_REQUEST = w_ch_onehot;
                    w_sc_n     = w_sc_inc;
                    w_vld_n    = 1'b0;
                    w_state_n  = (w_sc_inc == r_ns_l) ? S_NEXT : S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_dout_n  = w_data_word;
                w_vld_n   = 1'b1;
                w_state_n = S_DATA;
            end
            S_NEXT: begin
                w_mask_n = w_mask_rem;
                w_vld_n  = 1'b1;
                if (w_mask_rem != '0) begin
                    w_ch_n    = f_lowest(w_mask_rem);
                    w_dout_n  = f_header(f_lowest(w_mask_rem));
                    w_state_n = S_HEADER;
                end else begin
                    w_dout_n  = f_trailer(r_cnt);
                    w_state_n = S_TRAILER;
                end
            end
            S_TRAILER: begin
                if (w_xfer) begin
                    w_vld_n   = 1'b0;
                    w_state_n = S_FIN;
                end
            end
            S_FIN: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_vld_n   = 1'b0;
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_eos_q  <= 1'b0;
            r_ovr    <= 1'b0;
            r_vld    <= 1'b0;
            r_dout   <= '0;
            r_mask_l <= '0;
            r_ns_l   <= '0;
            r_ch     <= '0;
            r_sc     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_eos_q  <= EOS;
            if (w_eos_edge && r_state != S_IDLE) r_ovr <= 1'b1;
            r_vld    <= w_vld_n;
            r_dout   <= w_dout_n;
            r_mask_l <= w_mask_n;
            r_ns_l   <= w_ns_n;
            r_ch     <= w_ch_n;
            r_sc     <= w_sc_n;
            r_cnt    <= w_cnt_n;
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_VALID = r_vld;
    assign BUSY       = (r_state != S_IDLE) && (r_state != S_FIN);
    assign DONE       = (r_state == S_FIN);
    assign OVERRUN    = r_ovr;

endmodule

// File: tb/tb_chan_readout_sched.sv
// Bench for chan_readout_sched: per-channel sample-stream model driving CH_DATA and an event word-list reference.
// Honours CHAN_ID_EN when computing expected data-word low nibbles.
module tb_chan_readout_sched;

    localparam int CHAN = 8;

    logic              clk = 1'b0;
    logic              RST, EOS, DOUT_READY;
    logic [CHAN-1:0]   CHAN_MASK;
    logic [11:0]       SAMPLE_NUM;
    logic [12*CHAN-1:0] CH_DATA;
    logic [CHAN-1:0]   RD_REQUEST;
    logic [15:0]       DOUT;
    logic              DOUT_VALID, BUSY, DONE, OVERRUN;

    chan_readout_sched #(.CHAN(CHAN), .ADC_WIDTH(12), .WIDTH(16), .NS_BITS(12)) dut (
        .CLK(clk), .RST(RST), .EOS(EOS), .CHAN_MASK(CHAN_MASK), .SAMPLE_NUM(SAMPLE_NUM),
        .CH_DATA(CH_DATA), .RD_REQUEST(RD_REQUEST), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
        .DOUT_READY(DOUT_READY), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
    );

    always #10 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int unsigned seed;
    bit ovr_en = 1'b0;
    bit bp_mode = 1'b0;
    bit hold_eos = 1'b0;

    // Channel model: each channel presents sample number ptr[i]; a read request advances it.
    int ptr [CHAN];
    int base [CHAN];
    logic [15:0] cap[$];
    int done_cnt = 0, rd_viol = 0, stab_viol = 0;
    int q0, done0, rdv0, stv0;
    bit hold_prev = 1'b0;
    logic [15:0] prev_dout = '0;

    function automatic logic [11:0] samp(input int ch, input int idx, input int unsigned s, input bit o);
        int unsigned h;
        if (o && ch == 7) return 12'hABC;
        h = s + (32'(ch) * 32'h9E3779B9) + (32'(idx) * 32'h85EBCA6B);
        h = h ^ (h >> 15);
        h = h * 32'h2C1B3C6D;
        h = h ^ (h >> 12);
        return h[11:0];
    endfunction

    always_comb begin
        CH_DATA = '0;
        for (int i = 0; i < CHAN; i++) CH_DATA[i*12 +: 12] = samp(i, ptr[i], seed, ovr_en);
    end

    always @(posedge clk) begin
        for (int i = 0; i < CHAN; i++) if (RD_REQUEST[i]) ptr[i] <= ptr[i] + 1;
    end

    always @(negedge clk) begin
        if (DOUT_VALID && DOUT_READY) cap.push_back(DOUT);
        if (RD_REQUEST != '0 && !(DOUT_VALID && DOUT_READY)) rd_viol++;
        if ($countones(RD_REQUEST) > 1) rd_viol++;
        if (hold_prev && !(DOUT_VALID && DOUT == prev_dout)) stab_viol++;
        hold_prev = DOUT_VALID && !DOUT_READY;
        prev_dout = DOUT;
        if (DONE) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        DOUT_READY = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic begin_event(input logic [7:0] m, input int ns);
        CHAN_MASK  = m;
        SAMPLE_NUM = 12'(ns);
        for (int i = 0; i < CHAN; i++) base[i] = ptr[i];
        q0 = cap.size(); done0 = done_cnt; rdv0 = rd_viol; stv0 = stab_viol;
        EOS = 1'b1;
        cyc();
        if (!hold_eos) EOS = 1'b0;
        CHAN_MASK  = 8'($urandom);
        SAMPLE_NUM = 12'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == done0 && n < budget) begin
            cyc();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != done0), 32'd1);
    endtask

    task automatic check_event(input string tag, input logic [7:0] m, input int ns);
        logic [15:0] exp[$];
        int cnt = 0;
        int got;
        logic [3:0] nib;
        if (ns != 0) begin
            for (int i = 0; i < CHAN; i++) begin
                if (m[i]) begin
                    cnt++;
                    exp.push_back({4'hA, 4'(i), 8'h00});
`ifdef CHAN_ID_EN
                    nib = 4'(i);
`else
                    nib = 4'h0;
`endif
                    for (int k = 0; k < ns; k++) exp.push_back({samp(i, base[i] + k, seed, ovr_en), nib});
                end
            end
        end
        exp.push_back({4'hE, 4'h0, 8'(cnt)});
        got = cap.size() - q0;
        check({tag, "_nwords"}, 32'(got), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < got; k++)
            check($sformatf("%s_w%0d", tag, k), 32'(cap[q0 + k]), 32'(exp[k]));
        for (int i = 0; i < CHAN; i++)
            check($sformatf("%s_rdcnt%0d", tag, i), 32'(ptr[i] - base[i]), (m[i] && ns != 0) ? 32'(ns) : 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt - done0), 32'd1);
        check({tag, "_rd_only_on_xfer"}, 32'(rd_viol - rdv0), 32'd0);
        check({tag, "_dout_stable"}, 32'(stab_viol - stv0), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdreq"}, 32'(RD_REQUEST), 32'd0);
        check({tag, "_dout"}, 32'(DOUT), 32'd0);
        check({tag, "_valid"}, 32'(DOUT_VALID), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd0);
        check({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
    endtask

    initial begin
        logic [7:0] m;
        int ns, n;
        seed = $urandom;
        RST = 1'b1; EOS = 1'b0; DOUT_READY = 1'b1; CHAN_MASK = '0; SAMPLE_NUM = '0;
        repeat (3) cyc();
        check_idle_outputs("reset");
        RST = 1'b0;
        cyc();

        // Basic event with EOS held high afterwards: only one event may start.
        hold_eos = 1'b1;
        begin_event(8'h05, 3);
        check("busy_after_edge", 32'(BUSY), 32'd1);
        wait_done("basic", 500);
        repeat (10) cyc();
        check_event("basic", 8'h05, 3);
        EOS = 1'b0; hold_eos = 1'b0;
        cyc();

        bp_mode = 1'b1;
        begin_event(8'h05, 3);
        wait_done("bp", 2000);
        repeat (4) cyc();
        check_event("bp", 8'h05, 3);
        bp_mode = 1'b0;

        begin_event(8'h00, 3);
        wait_done("empty", 200);
        repeat (4) cyc();
        check_event("empty", 8'h00, 3);

        begin_event(8'hFF, 0);
        wait_done("ns0", 200);
        repeat (4) cyc();
        check_event("ns0", 8'hFF, 0);

        // Overrun: second EOS edge once data is flowing.
        begin_event(8'h06, 3);
        n = 0;
        while (cap.size() < q0 + 2 && n < 100) begin cyc(); n++; end
        EOS = 1'b1; cyc(); EOS = 1'b0;
        check("ovr_set", 32'(OVERRUN), 32'd1);
        wait_done("ovr", 500);
        repeat (20) cyc();
        check_event("ovr", 8'h06, 3);
        check("ovr_held", 32'(OVERRUN), 32'd1);
        check("ovr_no_second_busy", 32'(BUSY), 32'd0);
        RST = 1'b1; cyc();
        check("ovr_cleared", 32'(OVERRUN), 32'd0);
        RST = 1'b0; cyc();

        // Reset in the middle of channel 1 data.
        begin_event(8'h03, 4);
        n = 0;
        while (ptr[1] - base[1] < 1 && n < 300) begin cyc(); n++; end
        check("mid_reached_ch1", 32'(ptr[1] - base[1] >= 1), 32'd1);
        RST = 1'b1; cyc();
        check_idle_outputs("mid_rst");
        RST = 1'b0; cyc();
        begin_event(8'h0B, 2);
        wait_done("after_rst", 500);
        repeat (4) cyc();
        check_event("after_rst", 8'h0B, 2);

        for (int e = 0; e < 8; e++) begin
            m = 8'($urandom);
            ns = $urandom_range(1, 6);
            bp_mode = 1'($urandom_range(0, 1));
            begin_event(m, ns);
            wait_done($sformatf("rnd%0d", e), 3000);
            repeat (4) cyc();
            check_event($sformatf("rnd%0d", e), m, ns);
        end
        bp_mode = 1'b0;

        m = 8'(1 << $urandom_range(0, CHAN - 1));
        begin_event(m, 4095);
        wait_done("ns4095", 20000);
        repeat (4) cyc();
        check_event("ns4095", m, 4095);

        ovr_en = 1'b1;
        begin_event(8'h80, 1);
        wait_done("id", 200);
        repeat (4) cyc();
        check_event("id", 8'h80, 1);
        if (cap.size() >= q0 + 3) begin
            check("id_hdr", 32'(cap[q0]), 32'h0000A700);
`ifdef CHAN_ID_EN
            check("id_data", 32'(cap[q0 + 1]), 32'h0000ABC7);
`else
            check("id_data", 32'(cap[q0 + 1]), 32'h0000ABC0);
`endif
            check("id_trl", 32'(cap[q0 + 2]), 32'h0000E001);
        end
        ovr_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
